// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants and types for the ALU issue stage.
//   - MIPS-style opcode / funct encodings recognised by the decoder
//   - alu_op bit indices (one-hot position of each ALU operation)
//   - operand-select enums used between decode and operand muxing
// Optional feature macro used by the files of this block: ALU_ISSUE_ILLEGAL_EN.
package alu_issue_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OP_NUM     = 12;

    // alu_op bit positions (bit 0 .. bit 11)
    localparam int ALU_OP_ADD  = 0;
    localparam int ALU_OP_SUB  = 1;
    localparam int ALU_OP_SLT  = 2;
    localparam int ALU_OP_SLTU = 3;
    localparam int ALU_OP_AND  = 4;
    localparam int ALU_OP_NOR  = 5;
    localparam int ALU_OP_OR   = 6;
    localparam int ALU_OP_XOR  = 7;
    localparam int ALU_OP_SLL  = 8;
    localparam int ALU_OP_SRL  = 9;
    localparam int ALU_OP_SRA  = 10;
    localparam int ALU_OP_LUI  = 11;

    // Primary opcodes
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_SLTI    = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        SRC1_ZERO,
        SRC1_RS,
        SRC1_SA
    } src1_sel_e;

    typedef enum logic [1:0] {
        SRC2_ZERO,
        SRC2_RT,
        SRC2_SEXT,
        SRC2_ZEXT
    } src2_sel_e;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake + payload bundle around the ALU issue stage.
//   upstream  : in_valid / in_ready, in_instr, in_rs_value, in_rt_value
//   downstream: out_valid / out_ready, alu_op, alu_src1, alu_src2,
//               dest_reg, dest_we, out_illegal (only with ALU_ISSUE_ILLEGAL_EN)
// Modports:
//   slave  - the issue stage itself
//   master - the surrounding pipeline (register read in front, execute behind)
interface alu_issue_if
    import alu_issue_pkg::*;
();

    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [DATA_WIDTH-1:0] in_rs_value;
    logic [DATA_WIDTH-1:0] in_rt_value;

    logic                  out_valid;
    logic                  out_ready;
    logic [OP_NUM-1:0]     alu_op;
    logic [DATA_WIDTH-1:0] alu_src1;
    logic [DATA_WIDTH-1:0] alu_src2;
    logic [4:0]            dest_reg;
    logic                  dest_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic                  out_illegal;
`endif

    modport slave (
        input  in_valid, in_instr, in_rs_value, in_rt_value, out_ready,
        output in_ready, out_valid, alu_op, alu_src1, alu_src2, dest_reg, dest_we
`ifdef ALU_ISSUE_ILLEGAL_EN
        , output out_illegal
`endif
    );

    modport master (
        output in_valid, in_instr, in_rs_value, in_rt_value, out_ready,
        input  in_ready, out_valid, alu_op, alu_src1, alu_src2, dest_reg, dest_we
`ifdef ALU_ISSUE_ILLEGAL_EN
        , input out_illegal
`endif
    );

endinterface

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: purely combinational decode of one instruction word into
// the ALU operation (one-hot), both ALU operands, destination index and
// write enable. Illegal encodings yield an all-zero result.
// Ports:
//   instr_i      instruction word
//   rs_value_i   GPR[rs]
//   rt_value_i   GPR[rt]
//   alu_op_o     one-hot operation (zero when illegal)
//   alu_src1_o   first operand
//   alu_src2_o   second operand
//   dest_reg_o   destination GPR index
//   dest_we_o    destination write enable
//   illegal_o    decode failed (only with ALU_ISSUE_ILLEGAL_EN)
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] rs_value_i,
    input  logic [DATA_WIDTH-1:0] rt_value_i,
    output logic [OP_NUM-1:0]     alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_src1_o,
    output logic [DATA_WIDTH-1:0] alu_src2_o,
    output logic [4:0]            dest_reg_o,
    output logic                  dest_we_o
`ifdef ALU_ISSUE_ILLEGAL_EN
    , output logic                illegal_o
`endif
);

    logic [5:0]  opcode;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [4:0]  sa_field;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign opcode   = instr_i[31:26];
    assign rt_field = instr_i[20:16];
    assign rd_field = instr_i[15:11];
    assign sa_field = instr_i[10:6];
    assign funct    = instr_i[5:0];
    assign imm      = instr_i[15:0];

    // The rs index is resolved by the register file upstream; only its value
    // reaches this stage.
    logic unused_rs_field;
    assign unused_rs_field = ^instr_i[25:21];

    logic      legal;
    logic [3:0] op_idx;
    logic      dest_is_rd;
    src1_sel_e src1_sel;
    src2_sel_e src2_sel;

    always_comb begin
        legal      = 1'b1;
        op_idx     = 4'(ALU_OP_ADD);
        dest_is_rd = 1'b0;
        src1_sel   = SRC1_RS;
        src2_sel   = SRC2_RT;

        case (opcode)
            OPC_SPECIAL: begin
                dest_is_rd = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: op_idx = 4'(ALU_OP_ADD);
                    FN_SUB, FN_SUBU: op_idx = 4'(ALU_OP_SUB);
                    FN_SLT:          op_idx = 4'(ALU_OP_SLT);
                    FN_SLTU:         op_idx = 4'(ALU_OP_SLTU);
                    FN_AND:          op_idx = 4'(ALU_OP_AND);
                    FN_NOR:          op_idx = 4'(ALU_OP_NOR);
                    FN_OR:           op_idx = 4'(ALU_OP_OR);
                    FN_XOR:          op_idx = 4'(ALU_OP_XOR);
                    // Immediate-amount shifts take the amount from sa.
                    FN_SLL: begin op_idx = 4'(ALU_OP_SLL); src1_sel = SRC1_SA; end
                    FN_SRL: begin op_idx = 4'(ALU_OP_SRL); src1_sel = SRC1_SA; end
                    FN_SRA: begin op_idx = 4'(ALU_OP_SRA); src1_sel = SRC1_SA; end
                    // Variable shifts take the amount from rs.
                    FN_SLLV:         op_idx = 4'(ALU_OP_SLL);
                    FN_SRLV:         op_idx = 4'(ALU_OP_SRL);
                    FN_SRAV:         op_idx = 4'(ALU_OP_SRA);
                    default:         legal  = 1'b0;
                endcase
            end
            OPC_ADDI, OPC_ADDIU: begin op_idx = 4'(ALU_OP_ADD);  src2_sel = SRC2_SEXT; end
            OPC_SLTI:            begin op_idx = 4'(ALU_OP_SLT);  src2_sel = SRC2_SEXT; end
            OPC_SLTIU:           begin op_idx = 4'(ALU_OP_SLTU); src2_sel = SRC2_SEXT; end
            OPC_ANDI:            begin op_idx = 4'(ALU_OP_AND);  src2_sel = SRC2_ZEXT; end
            OPC_ORI:             begin op_idx = 4'(ALU_OP_OR);   src2_sel = SRC2_ZEXT; end
            OPC_XORI:            begin op_idx = 4'(ALU_OP_XOR);  src2_sel = SRC2_ZEXT; end
            OPC_LUI: begin
                op_idx   = 4'(ALU_OP_LUI);
                src1_sel = SRC1_ZERO;
                src2_sel = SRC2_ZEXT;
            end
            default: legal = 1'b0;
        endcase

        // Illegal encodings must not leak operand values downstream.
        if (!legal) begin
            src1_sel = SRC1_ZERO;
            src2_sel = SRC2_ZERO;
        end
    end

    always_comb begin
        alu_src1_o = '0;
        case (src1_sel)
            SRC1_RS: alu_src1_o = rs_value_i;
            SRC1_SA: alu_src1_o = DATA_WIDTH'(sa_field);
            default: alu_src1_o = '0;
        endcase
    end

    always_comb begin
        alu_src2_o = '0;
        case (src2_sel)
            SRC2_RT:   alu_src2_o = rt_value_i;
            SRC2_SEXT: alu_src2_o = {{(DATA_WIDTH-16){imm[15]}}, imm};
            SRC2_ZEXT: alu_src2_o = {{(DATA_WIDTH-16){1'b0}}, imm};
            default:   alu_src2_o = '0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < OP_NUM; gi++) begin : g_op_onehot
            assign alu_op_o[gi] = legal && (op_idx == 4'(gi));
        end
    endgenerate

    assign dest_reg_o = !legal ? 5'd0 : (dest_is_rd ? rd_field : rt_field);
    assign dest_we_o  = legal;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign illegal_o  = !legal;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: one-entry registered issue stage between register read and
// execute. Decodes the incoming instruction and holds the result behind a
// valid/ready handshake with backpressure and synchronous flush.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   flush  synchronous discard of the held instruction (blocks accept)
//   bus    alu_issue_if.slave: in_* handshake/operands, out_* handshake,
//          alu_op / alu_src1 / alu_src2 / dest_reg / dest_we payload,
//          out_illegal when ALU_ISSUE_ILLEGAL_EN is defined
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN.
module alu_issue_stage
    import alu_issue_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  flush,
    alu_issue_if.slave bus
);

    logic [OP_NUM-1:0]     dec_op;
    logic [DATA_WIDTH-1:0] dec_src1;
    logic [DATA_WIDTH-1:0] dec_src2;
    logic [4:0]            dec_dest;
    logic                  dec_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic                  dec_illegal;
`endif

    alu_issue_decode u_decode (
        .instr_i    (bus.in_instr),
        .rs_value_i (bus.in_rs_value),
        .rt_value_i (bus.in_rt_value),
        .alu_op_o   (dec_op),
        .alu_src1_o (dec_src1),
        .alu_src2_o (dec_src2),
        .dest_reg_o (dec_dest),
        .dest_we_o  (dec_we)
`ifdef ALU_ISSUE_ILLEGAL_EN
        , .illegal_o (dec_illegal)
`endif
    );

    logic                  valid_q,  valid_d;
    logic [OP_NUM-1:0]     op_q,     op_d;
    logic [DATA_WIDTH-1:0] src1_q,   src1_d;
    logic [DATA_WIDTH-1:0] src2_q,   src2_d;
    logic [4:0]            dest_q,   dest_d;
    logic                  we_q,     we_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic                  illegal_q, illegal_d;
`endif

    logic in_ready;
    logic accept;

    // The slot is free when empty or being drained this cycle; a flush cycle
    // never takes a new instruction.
    assign in_ready = (!valid_q || bus.out_ready) && !flush;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        dest_d  = dest_q;
        we_d    = we_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
        illegal_d = illegal_q;
`endif
        if (flush) begin
            // Flush wins over out_ready and returns payload to reset values.
            valid_d = 1'b0;
            op_d    = '0;
            src1_d  = '0;
            src2_d  = '0;
            dest_d  = '0;
            we_d    = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            illegal_d = 1'b0;
`endif
        end else if (accept) begin
            // Covers both fill-when-empty and drain-and-refill without a bubble.
            valid_d = 1'b1;
            op_d    = dec_op;
            src1_d  = dec_src1;
            src2_d  = dec_src2;
            dest_d  = dec_dest;
            we_d    = dec_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
            illegal_d = dec_illegal;
`endif
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dest_q  <= '0;
            we_q    <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            dest_q  <= dest_d;
            we_q    <= we_d;
`ifdef ALU_ISSUE_ILLEGAL_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_src1  = src1_q;
    assign bus.alu_src2  = src2_q;
    assign bus.dest_reg  = dest_q;
    assign bus.dest_we   = we_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
    assign bus.out_illegal = illegal_q;
`endif

endmodule
